// File: rtl/seven_seg_scanner_if.sv
// Bundle of the scan controller's data-side signals: display value and load
// strobe, live per-digit controls, and the anode/nibble outputs.
// Names are from the scanner's point of view (i_ into it, o_ out of it).
interface seven_seg_scanner_if;
  logic [15:0] i_value;
  logic        i_load;
  logic [3:0]  i_dp_in;
  logic [3:0]  i_digit_en;
  logic        i_lz_en;
  logic [3:0]  o_hex;
  logic [3:0]  o_an;
  logic        o_dp;
  logic        o_frame_tick;
  logic        o_pending;

  // Driver side: whoever supplies the value and reads the scan outputs.
  modport master (
    output i_value, i_load, i_dp_in, i_digit_en, i_lz_en,
    input  o_hex, o_an, o_dp, o_frame_tick, o_pending
  );

  // Scanner side.
  modport slave (
    input  i_value, i_load, i_dp_in, i_digit_en, i_lz_en,
    output o_hex, o_an, o_dp, o_frame_tick, o_pending
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a four-digit common-anode display.
// A slot counter walks the four digits; a shadow/display register pair makes
// value changes land only on frame boundaries so a digit never shows a mix of
// old and new data. Each slot starts with a blanking window to stop ghosting
// from the previous digit's segments. The nibble goes to an external
// combinational hex decoder.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                clk,
  input  logic                reset,
  seven_seg_scanner_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_sh;
  logic [15:0]      r_disp;
  logic             r_pending;

  logic             w_slotEnd;
  logic             w_boundary;
  logic [3:0]       w_upperZero;
  logic             w_dark;
  logic             w_lit;
  logic [3:0]       w_nibble;

  assign w_slotEnd  = (r_cnt == CNT_LAST);
  assign w_boundary = w_slotEnd && (r_idx == 2'd3);

  // Slot counter and digit index: one slot per REFRESH_DIV cycles, digits 0..3.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slotEnd) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Double buffer: loads park in the shadow and move to the display only at a
  // frame boundary; a load landing exactly on the boundary goes straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh      <= 16'h0000;
      r_disp    <= 16'h0000;
      r_pending <= 1'b0;
    end else if (bus.i_load) begin
      r_sh <= bus.i_value;
      if (w_boundary) begin
        r_disp    <= bus.i_value;
        r_pending <= 1'b0;
      end else begin
        r_pending <= 1'b1;
      end
    end else if (w_boundary && r_pending) begin
      r_disp    <= r_sh;
      r_pending <= 1'b0;
    end
  end

  // For each position, flag whether it and every nibble above it are zero;
  // digit 0 is never treated as a leading zero.
  always_comb begin
    w_upperZero    = 4'b0000;
    w_upperZero[3] = (r_disp[15:12] == 4'h0);
    w_upperZero[2] = w_upperZero[3] && (r_disp[11:8] == 4'h0);
    w_upperZero[1] = w_upperZero[2] && (r_disp[7:4] == 4'h0);
    w_upperZero[0] = 1'b0;
  end

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    w_nibble = r_disp[3:0];
    case (r_idx)
      2'd0: w_nibble = r_disp[3:0];
      2'd1: w_nibble = r_disp[7:4];
      2'd2: w_nibble = r_disp[11:8];
      2'd3: w_nibble = r_disp[15:12];
      default: w_nibble = r_disp[3:0];
    endcase
  end

  assign w_dark = ~bus.i_digit_en[r_idx] | (bus.i_lz_en & w_upperZero[r_idx]);
  assign w_lit  = (r_cnt >= CNT_BLANK) && !w_dark;

  // Drive the display pins: one active-low anode when lit, decimal point only
  // while its digit is actually lit.
  always_comb begin
    bus.o_an = 4'b1111;
    bus.o_dp = 1'b1;
    if (w_lit) begin
      bus.o_an = ~(4'b0001 << r_idx);
      bus.o_dp = ~bus.i_dp_in[r_idx];
    end
  end

  assign bus.o_hex        = w_nibble;
  assign bus.o_frame_tick = w_boundary;
  assign bus.o_pending    = r_pending;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a short refresh period.
// The reference model tracks elapsed cycles since reset and derives slot,
// digit and blanking with division/modulo, plus the spec's load rules.
module tb_seven_seg_scanner;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * RDIV;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seven_seg_scanner_if bus ();

  seven_seg_scanner #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  int          t        = 0;
  logic [15:0] mDisp    = 16'h0000;
  logic [15:0] mSh      = 16'h0000;
  logic        mPending = 1'b0;

  // Live control settings applied every cycle.
  logic [3:0] en   = 4'hF;
  logic [3:0] dpIn = 4'h0;
  logic       lz   = 1'b0;
  logic       sawAbcd;

  // Count one comparison and report it if the DUT disagrees.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at t=%0d (time %0t): got %h, expected %h",
               tag, t, $time, observed, expected);
    end
  endtask

  // Compare every output against what the model says for the current cycle.
  task automatic checkAll();
    int         idx;
    int         cnt;
    logic [3:0] nib;
    logic       dark;
    logic       lit;
    logic [3:0] expAn;
    logic       expDp;
    logic       expTick;
    logic [3:0] oneHot;
    idx  = (t / RDIV) % 4;
    cnt  = t % RDIV;
    nib  = 4'((mDisp >> (4 * idx)) & 16'h000F);
    dark = !en[idx] || (lz && idx >= 1 && (mDisp >> (4 * idx)) == 16'h0000);
    lit  = (cnt >= BLANK) && !dark;
    oneHot = 4'(1 << idx);
    expAn = lit ? ~oneHot : 4'hF;
    expDp = lit ? !dpIn[idx] : 1'b1;
    expTick = (cnt == RDIV - 1) && (idx == 3);
    checkOutput("hex", 16'(bus.o_hex), 16'(nib));
    checkOutput("an", 16'(bus.o_an), 16'(expAn));
    checkOutput("dp", 16'(bus.o_dp), 16'(expDp));
    checkOutput("frameTick", 16'(bus.o_frame_tick), 16'(expTick));
    checkOutput("pending", 16'(bus.o_pending), 16'(mPending));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic rst, input logic ld,
                               input logic [15:0] val);
    logic boundary;
    reset           = rst;
    bus.i_load      = ld;
    bus.i_value     = val;
    bus.i_dp_in     = dpIn;
    bus.i_digit_en  = en;
    bus.i_lz_en     = lz;
    boundary = (t % RDIV == RDIV - 1) && ((t / RDIV) % 4 == 3);
    @(posedge clk);
    if (rst) begin
      t = 0;
      mDisp = 16'h0000;
      mSh = 16'h0000;
      mPending = 1'b0;
    end else begin
      if (ld) begin
        mSh = val;
        if (boundary) begin
          mDisp = val;
          mPending = 1'b0;
        end else begin
          mPending = 1'b1;
        end
      end else if (boundary && mPending) begin
        mDisp = mSh;
        mPending = 1'b0;
      end
      t = (t + 1) % FRAME;
    end
    @(negedge clk);
    checkAll();
  endtask

  task automatic tick(input logic ld, input logic [15:0] val);
    applyStimulus(1'b0, ld, val);
  endtask

  // Advance (at least one cycle) until the model reaches frame position target.
  task automatic runTo(input int target);
    int n = 0;
    do begin
      tick(1'b0, 16'h0000);
      n++;
    end while (t != target && n < 2 * FRAME);
    if (t != target) checkOutput("runToBound", 16'(t), 16'(target));
  endtask

  initial begin
    bus.i_load = 1'b0;
    bus.i_value = 16'h0000;
    bus.i_dp_in = 4'h0;
    bus.i_digit_en = 4'hF;
    bus.i_lz_en = 1'b0;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("resetAn", 16'(bus.o_an), 16'h000F);
    checkOutput("resetDp", 16'(bus.o_dp), 16'h0001);

    // Basic scan of 1234.
    en = 4'hF; lz = 1'b0; dpIn = 4'h0;
    tick(1'b1, 16'h1234);
    checkOutput("basicPending", 16'(bus.o_pending), 16'h0001);
    runTo(FRAME - 1);
    checkOutput("basicTick", 16'(bus.o_frame_tick), 16'h0001);
    runTo(0);
    checkOutput("basicSlot0Blank", 16'(bus.o_an), 16'h000F);
    checkOutput("basicSlot0Hex", 16'(bus.o_hex), 16'h0004);
    runTo(2);
    checkOutput("basicSlot0Lit", 16'(bus.o_an), 16'h000E);
    runTo(RDIV + 2);
    checkOutput("basicSlot1Hex", 16'(bus.o_hex), 16'h0003);
    checkOutput("basicSlot1An", 16'(bus.o_an), 16'h000D);
    runTo(3 * RDIV + 7);
    checkOutput("basicSlot3An", 16'(bus.o_an), 16'h0007);

    // Leading-zero suppression.
    lz = 1'b1;
    tick(1'b1, 16'h0050);
    runTo(FRAME - 1);
    runTo(RDIV + 3);
    checkOutput("lzDigit1An", 16'(bus.o_an), 16'h000D);
    checkOutput("lzDigit1Hex", 16'(bus.o_hex), 16'h0005);
    runTo(2 * RDIV + 3);
    checkOutput("lzDigit2Dark", 16'(bus.o_an), 16'h000F);
    runTo(3 * RDIV + 3);
    checkOutput("lzDigit3Dark", 16'(bus.o_an), 16'h000F);
    tick(1'b1, 16'h0000);
    runTo(FRAME - 1);
    runTo(4);
    checkOutput("lzZeroDigit0", 16'(bus.o_an), 16'h000E);
    runTo(RDIV + 4);
    checkOutput("lzZeroDigit1", 16'(bus.o_an), 16'h000F);

    // Double load: last one wins, ABCD never displayed.
    lz = 1'b0;
    runTo(RDIV + 1);
    tick(1'b1, 16'hABCD);
    tick(1'b0, 16'h0000);
    tick(1'b1, 16'h00EF);
    runTo(FRAME - 1);
    checkOutput("dblPendingAtTick", 16'(bus.o_pending), 16'h0001);
    sawAbcd = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 16'h0000);
      if (bus.o_hex >= 4'hA && bus.o_hex <= 4'hD) sawAbcd = 1'b1;
      if (i == 0) checkOutput("dblPendingCleared", 16'(bus.o_pending), 16'h0000);
    end
    checkOutput("dblNoAbcd", 16'(sawAbcd), 16'h0000);

    // Load coincident with the frame boundary.
    runTo(FRAME - 1);
    tick(1'b1, 16'h9876);
    checkOutput("bndHex", 16'(bus.o_hex), 16'h0006);
    checkOutput("bndPending", 16'(bus.o_pending), 16'h0000);

    // Per-digit enables and decimal points.
    en = 4'b0101; dpIn = 4'b0011;
    runTo(2);
    checkOutput("enDigit0An", 16'(bus.o_an), 16'h000E);
    checkOutput("enDigit0Dp", 16'(bus.o_dp), 16'h0000);
    runTo(RDIV + 2);
    checkOutput("enDigit1Dark", 16'(bus.o_an), 16'h000F);
    checkOutput("enDigit1Dp", 16'(bus.o_dp), 16'h0001);
    runTo(2 * RDIV + 2);
    checkOutput("enDigit2An", 16'(bus.o_an), 16'h000B);
    checkOutput("enDigit2Dp", 16'(bus.o_dp), 16'h0001);

    // Reset mid-slot with a load pending.
    en = 4'hF; dpIn = 4'h0;
    runTo(RDIV + 1);
    tick(1'b1, 16'h5555);
    runTo(2 * RDIV + 5);
    checkOutput("rstPendingBefore", 16'(bus.o_pending), 16'h0001);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("rstAn", 16'(bus.o_an), 16'h000F);
    checkOutput("rstHex", 16'(bus.o_hex), 16'h0000);
    checkOutput("rstPending", 16'(bus.o_pending), 16'h0000);
    runTo(3);
    checkOutput("rstRestartAn", 16'(bus.o_an), 16'h000E);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      logic rst;
      logic ld;
      logic [15:0] val;
      if ($urandom_range(0, 31) == 0) begin
        en   = 4'($urandom);
        dpIn = 4'($urandom);
        lz   = 1'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      val = 16'($urandom);
      if ($urandom_range(0, 3) == 0) val = val & 16'h00FF;
      applyStimulus(rst, ld, val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for the Basys 3 four-digit common-anode display. It holds a double-buffered 16-bit display value and cycles through the four digits. For each digit it drives the active-low anode, the decimal point, and the 4-bit nibble that feeds the hex-to-seven-segment decoder directly downstream. Anti-ghosting blanking, leading-zero suppression, per-digit enables and frame-synchronous value updates are handled here, so the decoder stays purely combinational.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2 (1 kHz per digit at 100 MHz).
- BLANK_CYCLES, 2000: cycles at the start of each slot during which all anodes are off; must be < REFRESH_DIV.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  16  four nibbles; value[3:0] is digit 0 (rightmost, an[0]), value[15:12] is digit 3.
- load  in  1  one-cycle strobe; captures value into the shadow register.
- dp_in  in  4  decimal point request per digit, active-high, sampled live.
- digit_en  in  4  per-digit enable, active-high, sampled live.
- lz_en  in  1  leading-zero suppression enable.
- hex  out  4  nibble of the current digit, to the decoder.
- an  out  4  anode enables, active-low.
- dp  out  1  decimal point cathode, active-low.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  a loaded value is waiting for the next frame boundary.

## Operation
- State:
  - slot counter cnt, 0..REFRESH_DIV-1.
  - digit index idx, 0..3.
  - shadow register sh[15:0].
  - display register disp[15:0].
  - pending flag.
- cnt increments every cycle. At cnt = REFRESH_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
- Frame boundary: the cycle where cnt = REFRESH_DIV-1 and idx = 3.
  - frame_tick = 1 on that cycle only.
  - If pending, disp ← sh and pending ← 0.
- Loads:
  - load with no boundary: sh ← value, pending ← 1.
  - load while already pending: sh is overwritten; the last load wins.
  - load on the boundary cycle: disp ← value directly (bypassing sh), sh ← value, pending ← 0.
- hex = disp[4*idx+3 : 4*idx] at all times, including during blanking.
- Digit i is dark when any of the following holds:
  - digit_en[i] = 0;
  - lz_en = 1, i ≥ 1, and every nibble of disp at positions ≥ i is 0 (digit 0 is never suppressed).
- an = 4'b1111 when cnt < BLANK_CYCLES or the current digit is dark. Otherwise an[idx] = 0 and the other anode bits are 1.
- dp = ~dp_in[idx] when the anode is on; otherwise dp = 1.
- Outputs depend only on registered state plus the live dp_in, digit_en and lz_en. value and load reach the outputs only through registers.

## Timing
- Reset values:
  - cnt = 0, idx = 0, sh = 0, disp = 0, pending = 0.
  - an = 4'b1111, dp = 1, hex = 0, frame_tick = 0.
- Reset asserted mid-operation: all of the above on the next edge. A pending load is discarded. reset has priority over load.
- Scan timing:
  - Digit slot = REFRESH_DIV cycles; frame = 4·REFRESH_DIV cycles.
  - Anode lit for REFRESH_DIV − BLANK_CYCLES cycles per slot.
- Load-to-display latency: disp updates on the edge ending the boundary cycle, so the new value appears from slot 0 of the next frame.
  - Best case (load on the boundary cycle): 1 cycle.
  - Worst case: 4·REFRESH_DIV cycles.
- pending rises the cycle after a non-boundary load and falls on the edge after the boundary.
- frame_tick is high for exactly one cycle per frame, coincident with cnt = REFRESH_DIV-1, idx = 3.

## Test plan
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
- Basic scan:
  - Stimulus: reset, then load 16'h1234 with digit_en=4'hF, lz_en=0.
  - Response: pending=1 until the first frame_tick. In the following frame, slot 0 gives hex=4 with an=1110 for cycles 2–7 and 1111 for cycles 0–1. Slots 1–3 give hex=3/2/1 with an=1101/1011/0111.
- Leading zeros:
  - Stimulus: load 16'h0050 with lz_en=1.
  - Response: digits 3 and 2 keep an=1111. Digit 1 is lit with hex=5. Digit 0 is lit with hex=0.
  - Repeat with 16'h0000: only digit 0 is lit.
- Double load:
  - Stimulus: load 16'hABCD, then 16'h00EF, both mid-frame.
  - Response: the old disp is shown through the boundary. After the boundary, 00EF is shown; ABCD never appears. pending goes 1→0 on the edge after frame_tick.
- Boundary-coincident load:
  - Stimulus: load 16'h9876 on the frame_tick cycle.
  - Response: the next slot 0 shows hex=6. pending stays 0.
- Enables and dp:
  - Stimulus: digit_en=4'b0101, dp_in=4'b0011.
  - Response: digits 1 and 3 are dark with dp=1. Digit 0 is lit with dp=0. Digit 2 is lit with dp=1.
- Reset mid-slot:
  - Stimulus: assert reset at cnt=5, idx=2 with pending=1.
  - Response: next cycle an=1111, dp=1, hex=0, pending=0. The scan restarts at idx=0 with disp=0.
